vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-enable divider and frame-boundary halt
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 2,
  parameter int CW       = 11
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          run,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          vblank,
  output logic          sync,
  output logic          pix_stb,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] HT1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT1 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSS = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSE = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSS = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSE = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DMAX = DW'(PIX_DIV - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] hc, vc;
  logic pix_en, h_last, v_last;
  assign pix_en = (state == RUN) && (div_cnt == DMAX);
  assign h_last = hc == HT1;
  assign v_last = vc == VT1;
  assign sync   = 1'b0;
  // halt is only honoured when the last pixel of the frame is consumed
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = run ? RUN : IDLE;
    else
      state_nxt = (pix_en && h_last && v_last && !run) ? IDLE : RUN;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt     <= '0;
      hc          <= '0;
      vc          <= '0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b0;
      vblank      <= 1'b0;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_stb     <= pix_en;
      line_start  <= pix_en && hc == '0;
      frame_start <= pix_en && hc == '0 && vc == '0;
      if (frame_start) frame_cnt <= frame_cnt + 8'd1;
      if (state == IDLE) begin
        div_cnt <= '0;
        hc      <= '0;
        vc      <= '0;
      end else begin
        div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
        if (pix_en) begin
          DrawX  <= hc;
          DrawY  <= vc;
          blank  <= (hc < HA) && (vc < VA);
          vblank <= vc >= VA;
          hs     <= (hc >= HSS && hc < HSE) ? HS_POL : ~HS_POL;
          vs     <= (vc >= VSS && vc < VSE) ? VS_POL : ~VS_POL;
          hc     <= h_last ? '0 : hc + 1'b1;
          if (h_last) vc <= v_last ? '0 : vc + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors for a small divided mode and an XGA-width undivided inverted-polarity mode
module tb_vga_timing_gen;
  logic Clk = 1'b0, Reset = 1'b1, run_a = 1'b0, run_b = 1'b0;
  logic [5:0] xa, ya;
  logic hsa, vsa, bla, vbla, sya, stba, lsa, fsa;
  logic [7:0] fca;
  logic [10:0] xb, yb;
  logic hsb, vsb, blb, vbb, syb, stbb, lsb, fsb;
  logic [7:0] fcb;
  int n_chk = 0, n_fail = 0, cur = 0;

  // A: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), divide by 2, active-low syncs
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(2), .CW(6)) dut_a (
    .Clk(Clk), .Reset(Reset), .run(run_a), .DrawX(xa), .DrawY(ya), .hs(hsa), .vs(vsa),
    .blank(bla), .vblank(vbla), .sync(sya), .pix_stb(stba), .line_start(lsa),
    .frame_start(fsa), .frame_cnt(fca));

  // B: XGA horizontal 1024/24/136/160, V 4/1/2/1, no divider, active-high syncs
  vga_timing_gen #(.H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .CW(11)) dut_b (
    .Clk(Clk), .Reset(Reset), .run(run_b), .DrawX(xb), .DrawY(yb), .hs(hsb), .vs(vsb),
    .blank(blb), .vblank(vbb), .sync(syb), .pix_stb(stbb), .line_start(lsb),
    .frame_start(fsb), .frame_cnt(fcb));

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cur);
    $fatal(1);
  end

  typedef struct {
    int cyc, run, x, y, hs, vs, bl, vb, stb, ls, fs, fc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cur, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
    cur += n;
  endtask

  task automatic goto(input int c);
    if (c > cur) step(c - cur);
  endtask

  function automatic logic [18:0] pa(input int x, y, h, v, bl, vb, stb, ls, fs);
    return {6'(x), 6'(y), 1'(h), 1'(v), 1'(bl), 1'(vb), 1'(stb), 1'(ls), 1'(fs)};
  endfunction

  function automatic logic [18:0] a_vec();
    return {xa, ya, hsa, vsa, bla, vbla, stba, lsa, fsa};
  endfunction

  initial begin
    vec_t tbl[$];
    int x, y, miss, r;
    logic [36:0] eb;
    // cyc counts falling edges after reset release with run_a = 1; pixel k shows at 3+2k
    tbl.push_back('{1,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{3,   1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0});
    tbl.push_back('{4,   1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{5,   1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{17,  1, 7, 0, 1, 1, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{19,  1, 8, 0, 1, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{21,  1, 9, 0, 1, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{23,  1, 10, 0, 0, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{27,  1, 12, 0, 0, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{28,  1, 12, 0, 0, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{29,  1, 13, 0, 1, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{31,  1, 14, 0, 1, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{32,  1, 14, 0, 1, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{33,  1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 1});
    tbl.push_back('{123, 1, 0, 4, 1, 1, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{151, 1, 14, 4, 1, 1, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{153, 1, 0, 5, 1, 0, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{167, 1, 7, 5, 1, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{175, 1, 11, 5, 0, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{211, 1, 14, 6, 1, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{213, 1, 0, 7, 1, 1, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{241, 1, 14, 7, 1, 1, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{242, 1, 14, 7, 1, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{243, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1});
    tbl.push_back('{244, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2});

    step(2);
    chk("reset_a", a_vec(), pa(0, 0, 1, 1, 0, 0, 0, 0, 0));
    chk("reset_a_misc", {sya, fca}, 9'd0);
    chk("reset_b", {xb, yb, hsb, vsb, blb, vbb, syb, stbb, lsb, fsb, fcb}, 38'd0);

    Reset = 1'b0;
    run_a = 1'b1;
    cur = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      goto(tbl[i].cyc);
      run_a = 1'(tbl[i].run);
      chk($sformatf("vec%0d", i), a_vec(), pa(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
        tbl[i].bl, tbl[i].vb, tbl[i].stb, tbl[i].ls, tbl[i].fs));
      chk($sformatf("vec%0d_fc", i), fca, 64'(tbl[i].fc));
    end

    // full second frame at every pixel strobe
    for (int k = 121; k < 240; k++) begin
      goto(3 + 2 * k);
      x = k % 15;
      y = (k / 15) % 8;
      chk($sformatf("sweep_a_%0d_%0d", x, y), a_vec(), pa(x, y, !(x >= 10 && x < 13),
        !(y >= 5 && y < 7), x < 8 && y < 4, y >= 4, 1, x == 0, 0));
    end

    // a short run drop inside frame 3 is cancelled before the boundary
    goto(583);
    run_a = 1'b0;
    goto(603);
    run_a = 1'b1;
    goto(723);
    chk("cancel_fs", a_vec(), pa(0, 0, 1, 1, 1, 0, 1, 1, 1));
    chk("cancel_fc", fca, 64'd3);

    // drop run mid frame 4; frame completes then strobes stop and outputs hold
    goto(803);
    run_a = 1'b0;
    goto(961);
    chk("halt_last", a_vec(), pa(14, 7, 1, 1, 0, 1, 1, 0, 0));
    miss = 0;
    for (int c = 962; c <= 1000; c++) begin
      goto(c);
      if (stba !== 1'b0 || lsa !== 1'b0 || fsa !== 1'b0) miss++;
    end
    chk("halt_no_strobe", 64'(miss), 64'd0);
    chk("halt_hold", a_vec(), pa(14, 7, 1, 1, 0, 1, 0, 0, 0));
    chk("halt_fc", fca, 64'd4);

    run_a = 1'b1;
    goto(1002);
    chk("restart_wait", a_vec(), pa(14, 7, 1, 1, 0, 1, 0, 0, 0));
    goto(1003);
    chk("restart_fs", a_vec(), pa(0, 0, 1, 1, 1, 0, 1, 1, 1));
    chk("restart_fc", fca, 64'd4);

    // asynchronous reset mid frame at pixel (5,2)
    goto(1073);
    chk("pre_reset", a_vec(), pa(5, 2, 1, 1, 1, 0, 1, 0, 0));
    Reset = 1'b1;
    #1;
    chk("async_reset", a_vec(), pa(0, 0, 1, 1, 0, 0, 0, 0, 0));
    chk("async_reset_fc", fca, 64'd0);
    step(2);
    Reset = 1'b0;
    r = cur;
    goto(r + 2);
    chk("post_reset_wait", a_vec(), pa(0, 0, 1, 1, 0, 0, 0, 0, 0));
    goto(r + 3);
    chk("post_reset_fs", a_vec(), pa(0, 0, 1, 1, 1, 0, 1, 1, 1));
    chk("post_reset_fc", fca, 64'd0);
    run_a = 1'b0;

    // B: pixel k shows two falling edges after run is driven, one per clock
    run_b = 1'b1;
    r = cur;
    for (int k = 0; k <= 10752; k++) begin
      goto(r + 2 + k);
      x = k % 1344;
      y = (k / 1344) % 8;
      eb = {11'(x), 11'(y), 1'(x >= 1048 && x < 1184), 1'(y >= 5 && y < 7),
        1'(x < 1024 && y < 4), 1'(y >= 4), 1'b1, 1'(x == 0), 1'(x == 0 && y == 0),
        8'(k == 0 ? 0 : 1)};
      chk($sformatf("sweep_b_%0d_%0d", x, y),
        {xb, yb, hsb, vsb, blb, vbb, stbb, lsb, fsb, fcb}, eb);
    end
    chk("sync_b", syb, 64'd0);
    run_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
